// File: rtl/dram_fifo_wr_arb.sv
// Round-robin write arbiter/packer: two 16-bit sources into the 128-bit DRAM FIFO port.
// Optional idle-timeout zero padding of partial entries when WR_ARB_PAD_TIMEOUT_EN is defined.
module dram_fifo_wr_arb #(
    parameter int unsigned BURST       = 16,
    parameter int unsigned PAD_TIMEOUT = 255
) (
    input  logic         ifclk,
    input  logic         reset,
    input  logic [15:0]  s0_data,
    input  logic         s0_valid,
    output logic         s0_ready,
    input  logic [15:0]  s1_data,
    input  logic         s1_valid,
    output logic         s1_ready,
    output logic [127:0] DI,
    output logic         WREN,
    input  logic         FULL,
    output logic [1:0]   grant,
    output logic [7:0]   pad_cnt
);

    if (BURST < 1 || BURST > 255) begin : g_burst_range
        $error("BURST out of range 1..255");
    end
    if (PAD_TIMEOUT < 1 || PAD_TIMEOUT > 255) begin : g_pad_range
        $error("PAD_TIMEOUT out of range 1..255");
    end

    localparam logic [7:0] BURST_LIM = 8'(BURST);

    typedef enum logic [1:0] {IDLE, G0, G1} state_t;

    state_t         state, state_nxt;
    logic           last;
    logic [111:0]   pack;
    logic [2:0]     pack_cnt;
    logic [7:0]     burst_cnt;
    logic           pend;
    logic [127:0]   di_q;

    logic           granted;
    logic           sel_valid;
    logic [15:0]    sel_data;
    logic           oth_valid;
    logic           blocked;
    logic           pad_active;
    logic           acc;
    logic           shift;
    logic [15:0]    shift_word;
    logic           complete;
    logic [2:0]     pack_cnt_nxt;
    logic [7:0]     burst_cnt_inc;
    logic           boundary;

    // Datapath decode for the currently granted source
    always_comb begin
        granted       = (state != IDLE);
        sel_valid     = 1'b0;
        sel_data      = '0;
        oth_valid     = 1'b0;
        if (state == G0) begin
            sel_valid = s0_valid;
            sel_data  = s0_data;
            oth_valid = s1_valid;
        end else if (state == G1) begin
            sel_valid = s1_valid;
            sel_data  = s1_data;
            oth_valid = s0_valid;
        end
        blocked       = pend & FULL & (pack_cnt == 3'd7);
        acc           = granted & sel_valid & ~blocked & ~pad_active;
        shift         = acc | (pad_active & ~blocked);
        shift_word    = acc ? sel_data : '0;
        complete      = shift & (pack_cnt == 3'd7);
        pack_cnt_nxt  = shift ? pack_cnt + 3'd1 : pack_cnt;
        burst_cnt_inc = (complete && burst_cnt != 8'hFF) ? burst_cnt + 8'd1 : burst_cnt;
        boundary      = granted & (pack_cnt_nxt == 3'd0);
    end

    always_ff @(posedge ifclk) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state_nxt == G0 && state != G0) begin
                last <= 1'b0;
            end else if (state_nxt == G1 && state != G1) begin
                last <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (s0_valid && s1_valid) begin
                    state_nxt = last ? G0 : G1;
                end else if (s0_valid) begin
                    state_nxt = G0;
                end else if (s1_valid) begin
                    state_nxt = G1;
                end
            end
            G0, G1: begin
                // Grant may only move at an entry boundary; burst switch takes priority
                if (boundary) begin
                    if (burst_cnt_inc >= BURST_LIM && oth_valid) begin
                        state_nxt = (state == G0) ? G1 : G0;
                    end else if (!sel_valid) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant    = 2'b00;
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        case (state)
            G0: begin
                grant    = 2'b01;
                s0_ready = ~blocked & ~pad_active;
            end
            G1: begin
                grant    = 2'b10;
                s1_ready = ~blocked & ~pad_active;
            end
            default: grant = 2'b00;
        endcase
        WREN = pend & ~FULL;
    end

    always_ff @(posedge ifclk) begin
        if (reset) begin
            pack      <= '0;
            pack_cnt  <= '0;
            burst_cnt <= '0;
            pend      <= 1'b0;
            di_q      <= '0;
        end else begin
            if (shift) begin
                pack <= {shift_word, pack[111:16]};
            end
            pack_cnt  <= pack_cnt_nxt;
            burst_cnt <= (state_nxt != state) ? '0 : burst_cnt_inc;
            if (complete) begin
                di_q <= {shift_word, pack};
            end
            // A completing entry keeps pend set even while the previous one drains
            pend <= complete | (pend & FULL);
        end
    end

    assign DI = di_q;

`ifdef WR_ARB_PAD_TIMEOUT_EN
    localparam logic [7:0] PAD_LIM = 8'(PAD_TIMEOUT);

    logic [7:0] idle_cnt;
    logic [7:0] pad_cnt_q;

    assign pad_active = granted & (pack_cnt != 3'd0) & (idle_cnt >= PAD_LIM);

    always_ff @(posedge ifclk) begin
        if (reset) begin
            idle_cnt  <= '0;
            pad_cnt_q <= '0;
        end else begin
            if (!granted || pack_cnt_nxt == 3'd0 || acc) begin
                idle_cnt <= '0;
            end else if (idle_cnt < PAD_LIM) begin
                idle_cnt <= idle_cnt + 8'd1;
            end
            if (complete && pad_active && pad_cnt_q != 8'hFF) begin
                pad_cnt_q <= pad_cnt_q + 8'd1;
            end
        end
    end

    assign pad_cnt = pad_cnt_q;
`else
    assign pad_active = 1'b0;
    assign pad_cnt    = '0;
`endif

endmodule

// File: tb/tb_dram_fifo_wr_arb.sv
// Directed bench for dram_fifo_wr_arb: vector table plus multi-cycle sequences and a word scoreboard.
module tb_dram_fifo_wr_arb;

    logic         ifclk = 1'b0;
    logic         reset;
    logic [15:0]  s0_data, s1_data;
    logic         s0_valid, s1_valid;
    logic         s0_ready, s1_ready;
    logic [127:0] DI;
    logic         WREN;
    logic         FULL;
    logic [1:0]   grant;
    logic [7:0]   pad_cnt;

    always #5 ifclk = ~ifclk;

    dram_fifo_wr_arb #(.BURST(2), .PAD_TIMEOUT(10)) dut (
        .ifclk    (ifclk),
        .reset    (reset),
        .s0_data  (s0_data),
        .s0_valid (s0_valid),
        .s0_ready (s0_ready),
        .s1_data  (s1_data),
        .s1_valid (s1_valid),
        .s1_ready (s1_ready),
        .DI       (DI),
        .WREN     (WREN),
        .FULL     (FULL),
        .grant    (grant),
        .pad_cnt  (pad_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard: accepted words in order; each write consumes eight of them
    logic [15:0]  sbq[$];
    logic [15:0]  wr_log[$];
    int           wr_count = 0;
    logic [127:0] mon_exp;

    always @(negedge ifclk) begin
        if (!reset) begin
            chk("no_wren_while_full", 128'(WREN & FULL), 128'(0));
            chk("single_ready", 128'(s0_ready & s1_ready), 128'(0));
            if (WREN) begin
                wr_count++;
                wr_log.push_back(DI[15:0]);
                if (sbq.size() < 8) begin
                    chk("sb_underflow", 128'(sbq.size()), 128'(8));
                end else begin
                    for (int i = 0; i < 8; i++) mon_exp[i*16 +: 16] = sbq.pop_front();
                    chk("sb_di", DI, mon_exp);
                end
            end
            if (s0_valid && s0_ready) sbq.push_back(s0_data);
            if (s1_valid && s1_ready) sbq.push_back(s1_data);
        end
    end

    logic       acc0, acc1, wr_s, r0_s;
    logic [1:0] gr_s;

    task automatic tick();
        @(negedge ifclk);
        acc0 = s0_valid & s0_ready;
        acc1 = s1_valid & s1_ready;
        wr_s = WREN;
        r0_s = s0_ready;
        gr_s = grant;
        @(posedge ifclk);
        #1;
        if (acc0) s0_data++;
        if (acc1) s1_data++;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        sbq.delete();
        @(posedge ifclk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic         s0v;
        logic [15:0]  s0d;
        logic         full;
        logic         er0;
        logic         ewr;
        logic [1:0]   egr;
        logic         cdi;
        logic [127:0] edi;
    } vec_t;

    vec_t tv[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, idle, c, viol, base;
        bit first, got;
        logic [127:0] exp_e;

        reset = 1'b1; s0_valid = 1'b0; s1_valid = 1'b0;
        s0_data = '0; s1_data = '0; FULL = 1'b0;
        repeat (2) @(posedge ifclk);
        #1;
        reset = 1'b0;

        // Single source: reset state, grant latency, 8-word pack, write one cycle later
        tv[0]  = '{1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 128'h0};
        tv[1]  = '{1'b1, 16'h1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 128'h0};
        for (int k = 1; k <= 8; k++)
            tv[k+1] = '{1'b1, 16'(k), 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 128'h0};
        tv[10] = '{1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1,
                   128'h0008_0007_0006_0005_0004_0003_0002_0001};
        tv[11] = '{1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 128'h0};
        chk("reset_pad_cnt", 128'(pad_cnt), 128'(0));
        for (int i = 0; i < 12; i++) begin
            s0_valid = tv[i].s0v;
            s0_data  = tv[i].s0d;
            FULL     = tv[i].full;
            @(negedge ifclk);
            chk($sformatf("tv%0d_s0_ready", i), 128'(s0_ready), 128'(tv[i].er0));
            chk($sformatf("tv%0d_s1_ready", i), 128'(s1_ready), 128'(0));
            chk($sformatf("tv%0d_wren", i), 128'(WREN), 128'(tv[i].ewr));
            chk($sformatf("tv%0d_grant", i), 128'(grant), 128'(tv[i].egr));
            if (tv[i].cdi) chk($sformatf("tv%0d_di", i), DI, tv[i].edi);
            @(posedge ifclk);
            #1;
        end

        // Round-robin with BURST=2: two entries per source, no bubbles
        FULL = 1'b0;
        do_reset();
        wr_log.delete();
        s0_data = 16'h1000; s1_data = 16'h2000;
        s0_valid = 1'b1; s1_valid = 1'b1;
        n = 0; idle = 0; first = 0;
        for (c = 0; c < 200 && n < 64; c++) begin
            tick();
            if (acc0 || acc1) begin
                n++;
                first = 1;
            end else if (first) begin
                idle++;
            end
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
        tick(); tick();
        chk("rr_words", 128'(n), 128'(64));
        chk("rr_idle_cycles", 128'(idle), 128'(0));
        chk("rr_writes", 128'(wr_log.size()), 128'(8));
        for (int k = 0; k < 8 && k < wr_log.size(); k++)
            chk($sformatf("rr_entry%0d", k), 128'(wr_log[k]),
                128'(16'((((k / 2) % 2) != 0 ? 16'h2000 : 16'h1000) + 16'(((k / 4) * 2 + k % 2) * 8))));

        // Mid-entry stop: three words from s0, s1 waiting
        do_reset();
        s0_data = 16'hA001; s1_data = 16'hB000;
        s0_valid = 1'b1; s1_valid = 1'b1;
        n = 0;
        for (c = 0; c < 10 && n < 3; c++) begin
            tick();
            if (acc0) n++;
        end
        s0_valid = 1'b0;
        chk("mid_accepts", 128'(n), 128'(3));
        viol = 0;
        for (c = 0; c < 8; c++) begin
            tick();
            if (gr_s != 2'b01 || wr_s || acc1) viol++;
        end
        chk("mid_stall_hold", 128'(viol), 128'(0));
`ifdef WR_ARB_PAD_TIMEOUT_EN
        for (int k = 0; k < 5; k++) sbq.push_back(16'h0);
        got = 0;
        for (c = 0; c < 40 && !got; c++) begin
            tick();
            if (wr_s) got = 1;
        end
        chk("pad_write", 128'(got), 128'(1));
        chk("pad_cnt_one", 128'(pad_cnt), 128'(1));
        got = 0;
        for (c = 0; c < 10 && !got; c++) begin
            tick();
            if (gr_s == 2'b10) got = 1;
        end
        chk("pad_grant_moves", 128'(got), 128'(1));
`else
        for (c = 0; c < 30; c++) begin
            tick();
            if (gr_s != 2'b01 || wr_s || acc1) viol++;
        end
        chk("mid_stall_forever", 128'(viol), 128'(0));
        chk("no_pad_cnt", 128'(pad_cnt), 128'(0));
`endif
        s1_valid = 1'b0;

        // Backpressure: FULL for 20 cycles, then release with back-to-back writes
        FULL = 1'b1;
        do_reset();
        s0_data = 16'h0001;
        s0_valid = 1'b1;
        n = 0;
        base = wr_count;
        for (c = 0; c < 20; c++) begin
            tick();
            if (acc0) n++;
        end
        chk("bp_accepts", 128'(n), 128'(15));
        chk("bp_ready_low", 128'(r0_s), 128'(0));
        chk("bp_no_wren", 128'(wr_count - base), 128'(0));
        FULL = 1'b0;
        tick();
        chk("bp_wren_on_release", 128'(wr_s), 128'(1));
        chk("bp_accept_16th", 128'(acc0), 128'(1));
        s0_valid = 1'b0;
        tick();
        chk("bp_wren_back_to_back", 128'(wr_s), 128'(1));
        tick();
        chk("bp_wren_done", 128'(wr_s), 128'(0));
        chk("bp_sb_empty", 128'(sbq.size()), 128'(0));
        chk("bp_write_total", 128'(wr_count - base), 128'(2));

        // Reset with pack_cnt=5 and pend=1
        FULL = 1'b1;
        do_reset();
        s0_data = 16'h0101;
        s0_valid = 1'b1;
        n = 0;
        for (c = 0; c < 30 && n < 13; c++) begin
            tick();
            if (acc0) n++;
        end
        chk("rm_accepts", 128'(n), 128'(13));
        do_reset();
        FULL = 1'b0;
        @(negedge ifclk);
        chk("rm_s0_ready", 128'(s0_ready), 128'(0));
        chk("rm_s1_ready", 128'(s1_ready), 128'(0));
        chk("rm_wren", 128'(WREN), 128'(0));
        chk("rm_di", DI, 128'h0);
        chk("rm_grant", 128'(grant), 128'(0));
        chk("rm_pad_cnt", 128'(pad_cnt), 128'(0));
        @(posedge ifclk);
        #1;
        s0_data = 16'h00C1;
        s0_valid = 1'b1;
        n = 0;
        for (c = 0; c < 20 && n < 8; c++) begin
            tick();
            if (acc0) n++;
        end
        s0_valid = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) exp_e[k*16 +: 16] = 16'(16'h00C1 + 16'(k));
        chk("rm_repack_wren", 128'(wr_s), 128'(1));
        chk("rm_repack_di", DI, exp_e);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
